// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - raster test-pattern source streaming 24-bit pixels over valid/ready
// Optional feature macro: VIDEO_PATTERN_GRID_OVERLAY_EN (white 64-px grid over every pattern).
module video_pattern_gen #(
  parameter int Width  = 1040,
  parameter int Height = 666
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic [23:0] video,
  output logic        video_valid,
  input  logic        video_ready,
  output logic        frame_done,
  output logic [7:0]  frame_count
);
  localparam logic [11:0] XLast = 12'(Width - 1);
  localparam logic [11:0] YLast = 12'(Height - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t      state;
  logic [11:0] x;
  logic [11:0] y;
  logic [1:0]  mode_r;
  logic [23:0] color_r;
  logic        xfer;
  logic        last_px;

  assign xfer    = video_valid & video_ready;
  assign last_px = (x == XLast) && (y == YLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      video_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      x           <= 12'd0;
      y           <= 12'd0;
      mode_r      <= 2'd0;
      color_r     <= 24'h0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= STREAM;
            video_valid <= 1'b1;
            mode_r      <= pattern_sel;
            color_r     <= solid_color;
            x           <= 12'd0;
            y           <= 12'd0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_px) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
              x           <= 12'd0;
              y           <= 12'd0;
              // Back-to-back frames re-sample the pattern controls with no idle bubble.
              if (enable) begin
                mode_r  <= pattern_sel;
                color_r <= solid_color;
              end else begin
                state       <= IDLE;
                video_valid <= 1'b0;
              end
            end else if (x == XLast) begin
              x <= 12'd0;
              y <= y + 12'd1;
            end else begin
              x <= x + 12'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          video_valid <= 1'b0;
        end
      endcase
    end
  end

  logic [2:0]  bar;
  logic [23:0] pattern;
  logic [23:0] pixel;

  always_comb begin
    bar = x[9:7];
    case (mode_r)
      2'd0:    pattern = {{8{~bar[2]}}, {8{~bar[1]}}, {8{~bar[0]}}};
      2'd1:    pattern = {x[7:0], y[7:0], frame_count};
      2'd2:    pattern = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
      default: pattern = color_r;
    endcase
  end

`ifdef VIDEO_PATTERN_GRID_OVERLAY_EN
  assign pixel = ((x[5:0] == 6'd0) || (y[5:0] == 6'd0)) ? 24'hFFFFFF : pattern;
`else
  assign pixel = pattern;
`endif

  // Blanked outside STREAM so the bus reads zero in reset and while idle.
  assign video = video_valid ? pixel : 24'h000000;

endmodule
